// File: rtl/mem_mp.sv
// rtl/mem_mp.sv - round-robin arbitrated multi-port word memory with tagged fixed-latency reads
//
// Several requesters share one storage array. Each port raises req with we/addr/w_data
// held stable. A port is accepted on a rising edge where req[i] & gnt[i]. Writes update the
// array at the accept edge and produce no response. Reads sample the array at the accept
// edge and return READ_LATENCY cycles later on r_valid/r_port/r_data.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; clears pipeline and arbiter, keeps array contents
//   req      in   [PORTS]            per-port request
//   we       in   [PORTS]            per-port op, 1 = write, 0 = read
//   addr     in   [PORTS*ADDR_SIZE]  port i at [i*ADDR_SIZE +: ADDR_SIZE]
//   w_data   in   [PORTS*WORD_SIZE]  port i at [i*WORD_SIZE +: WORD_SIZE]
//   gnt      out  [PORTS]            one-hot or zero, combinational
//   r_valid  out                     one-cycle pulse per accepted read
//   r_port   out  [PORT_W]           issuing port of the returning read
//   r_data   out  [WORD_SIZE]        read data; r_port/r_data hold while r_valid = 0
module mem_mp #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDR_SIZE    = 16,
  parameter int WORD_COUNT   = 65536,
  parameter int PORTS        = 2,
  parameter int READ_LATENCY = 1,
  localparam int PORT_W      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PORTS-1:0]           req,
  input  logic [PORTS-1:0]           we,
  input  logic [PORTS*ADDR_SIZE-1:0] addr,
  input  logic [PORTS*WORD_SIZE-1:0] w_data,
  output logic [PORTS-1:0]           gnt,
  output logic                       r_valid,
  output logic [PORT_W-1:0]          r_port,
  output logic [WORD_SIZE-1:0]       r_data
);

  localparam int AW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [ADDR_SIZE:0] WC_LIMIT = (ADDR_SIZE + 1)'(WORD_COUNT);

  logic [WORD_SIZE-1:0] mem [WORD_COUNT];

  logic [PORT_W-1:0]    last;
  logic [PORT_W-1:0]    sel;
  logic [PORT_W-1:0]    hi_idx;
  logic [PORT_W-1:0]    lo_idx;
  logic                 hi_found;
  logic                 lo_found;
  logic                 accept;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic                 in_range;
  logic [AW-1:0]        idx;
  logic                 wr_en;
  logic                 rd_en;
  logic [WORD_SIZE-1:0] rd_word;

  // Rotating priority: the lowest requester above `last` wins; if none, wrap to the
  // lowest requester overall. Scanning downward leaves the lowest match in each slot.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = PORT_W'(i);
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = PORT_W'(i);
        end
      end
    end
    accept = !reset && lo_found;
    sel    = hi_found ? hi_idx : lo_idx;

    gnt       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (int'(sel) == i) begin
        gnt[i]    = accept;
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_SIZE +: ADDR_SIZE];
        sel_wdata = w_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Out-of-range accesses must not alias onto low words through the truncated index.
  assign in_range = {1'b0, sel_addr} < WC_LIMIT;
  assign idx      = sel_addr[AW-1:0];
  assign wr_en    = accept && sel_we && in_range;
  assign rd_en    = accept && !sel_we;
  assign rd_word  = in_range ? mem[idx] : '0;

  // Array has no reset: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= sel_wdata;
    end
  end

  // Response pipeline. Stage 0 loads at the accept edge; the last stage drives the outputs.
  // Port/data stages only advance behind a valid bit, so the output stage holds the last
  // response while r_valid is low.
  logic                 pv [READ_LATENCY];
  logic [PORT_W-1:0]    pp [READ_LATENCY];
  logic [WORD_SIZE-1:0] pd [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= PORT_W'(PORTS - 1);
      for (int i = 0; i < READ_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pp[i] <= '0;
        pd[i] <= '0;
      end
    end else begin
      if (accept) begin
        last <= sel;
      end
      pv[0] <= rd_en;
      if (rd_en) begin
        pp[0] <= sel;
        pd[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pp[i] <= pp[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  assign r_valid = pv[READ_LATENCY-1];
  assign r_port  = pp[READ_LATENCY-1];
  assign r_data  = pd[READ_LATENCY-1];

endmodule
